n64_vmux: RTL and testbench
===========================

// Module: n64_vmux
// PURPOSE
// - Transmit side of the N64 digital video bus: serialises parallel pixels (sync nibble + R/G/B) into the
//   4-phase nDSYNC/D stream consumed by n64_vdemux. Used for pattern sources and demux loopback benches.
// - Pixels enter via valid/ready into a small FIFO. One pixel is emitted per 4 VCLK: sync phase, R, G, B.
// PARAMETERS
// - color_width   7  bits per colour component and width of D_o
// - FIFO_DEPTH    2  input FIFO entries, power of two, >=2
// - UFLOW_CNT_W   8  width of saturating underflow counter
// PORTS
// - VCLK          in   1   video clock
// - nRST          in   1   reset, synchronous, active-low
// - en_i          in   1   transmit enable, sampled at phase 0 only
// - n15bit_mode_i in   1   1: send full 7-bit colours; 0: send {c[6:2],2'b00}
// - pix_valid_i   in   1   input pixel valid
// - pix_ready_o   out  1   FIFO not full
// - pix_sync_i    in   4   {nVSYNC,nCLAMP,nHSYNC,nCSYNC}
// - pix_r_i/g_i/b_i in 7   colour components
// - nDSYNC_o      out  1   low during sync phase (registered)
// - D_o           out  7   bus data (registered)
// - phase_o       out  2   current phase counter 0..3
// - uflow_o       out  1   one-cycle pulse: FIFO empty at pixel start
// - uflow_cnt_o   out  UFLOW_CNT_W  saturating underflow count
// BEHAVIOUR
// - Reset (nRST low at VCLK edge): FIFO emptied, phase=0, nDSYNC_o=1, D_o=0, uflow_o=0, uflow_cnt_o=0,
//   last_sync=4'hF. Mid-pixel reset aborts the pixel; first pixel after release starts at phase 0.
// - FIFO: push when pix_valid_i && pix_ready_o; pix_ready_o = !full (registered occupancy, no bypass).
//   Pop only in a phase-0 cycle with en_i=1. Push and pop same cycle: both happen, occupancy unchanged.
//   Push into empty FIFO in a pop cycle: pop sees empty -> underflow; pushed pixel kept for next pixel.
// - Phase counter: at phase 0 with en_i=0 -> holds 0, nDSYNC_o<=1, D_o<=0, no pop, no underflow.
//   Otherwise increments 0->1->2->3->0 every cycle; en_i ignored at phases 1..3 (pixel always completes).
// - Phase 0 (en_i=1): nDSYNC_o<=0; D_o<={3'b000,head.sync}; cur colours<=head RGB; last_sync<=head.sync.
//   If empty: D_o<={3'b000,last_sync}, cur colours<=0, uflow_o<=1, uflow_cnt_o+=1 saturating at all-ones.
// - Phase 1/2/3: nDSYNC_o<=1; D_o<=mask(cur R / G / B); mask = n15bit_mode_i ? c : {c[6:2],2'b00},
//   n15bit_mode_i sampled each phase cycle.
// - Latency: registered bus outputs lag phase_o by one cycle; FIFO push to sync on bus >=2 cycles.
// - uflow_o is 0 in every cycle except the registered phase-0 underflow cycle.
// - Loopback n64_vmux -> n64_vdemux (matching n15bit mode, deblur off, gamma off) reproduces pixels in order.
// TESTING
// - Reset, push {sync=F,R=55,G=2A,B=7F}, 15bit=1 -> nDSYNC 0,1,1,1; D 0F,55,2A,7F; then underflow frames.
// - Same pixel, 15bit=0 -> D 0F,54,28,7C.
// - Never push, en_i=1 -> D 0F,00,00,00 repeating, uflow_o every 4 cycles, uflow_cnt_o stops at FF after 300.
// - Burst of 5 pixels, depth 2 -> pix_ready_o low when full, all 5 emitted in order, zero underflows.
// - Drop en_i at phase 2 -> B phase still emitted, then nDSYNC_o=1, D_o=0, phase_o=0 until en_i returns.
// - nRST low at phase 2 -> next cycle nDSYNC_o=1, D_o=0, pix_ready_o=1, uflow_cnt_o=0; restart at phase 0.

Source files
------------

// File: rtl/n64_vmux_if.sv
// Pixel input channel of n64_vmux: valid/ready handshake carrying one parallel pixel.
//   pix_valid  source -> sink  pixel valid
//   pix_ready  sink -> source  sink can accept a pixel this cycle
//   pix_sync   source -> sink  {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
//   pix_r/g/b  source -> sink  colour components, color_width bits each
interface n64_vmux_if #(
  parameter int unsigned color_width = 7
) ();
  logic                   pix_valid;
  logic                   pix_ready;
  logic [3:0]             pix_sync;
  logic [color_width-1:0] pix_r;
  logic [color_width-1:0] pix_g;
  logic [color_width-1:0] pix_b;

  modport master (
    output pix_valid,
    output pix_sync,
    output pix_r,
    output pix_g,
    output pix_b,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_sync,
    input  pix_r,
    input  pix_g,
    input  pix_b,
    output pix_ready
  );
endinterface

// File: rtl/n64_vmux.sv
// N64 digital video bus transmitter. Parallel pixels arrive over a valid/ready channel into a small
// FIFO and are serialised onto the 4-phase nDSYNC/D bus: sync nibble, R, G, B (one VCLK each).
// Ports:
//   VCLK           video clock
//   nRST           synchronous active-low reset
//   en_i           transmit enable, only looked at when a new pixel would start (phase 0)
//   n15bit_mode_i  1: full colours on the bus, 0: low two colour bits forced to zero
//   pix            pixel input channel (slave side of n64_vmux_if)
//   nDSYNC_o       low during the sync phase (registered)
//   D_o            bus data (registered)
//   phase_o        phase counter 0..3; the bus outputs lag it by one cycle
//   uflow_o        one-cycle pulse when a pixel starts with the FIFO empty
//   uflow_cnt_o    saturating count of underflows
module n64_vmux #(
  parameter int unsigned color_width = 7,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned UFLOW_CNT_W = 8
) (
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   en_i,
  input  logic                   n15bit_mode_i,
  n64_vmux_if.slave              pix,
  output logic                   nDSYNC_o,
  output logic [color_width-1:0] D_o,
  output logic [1:0]             phase_o,
  output logic                   uflow_o,
  output logic [UFLOW_CNT_W-1:0] uflow_cnt_o
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned PadW = color_width - 4;

  typedef struct packed {
    logic [3:0]             sync;
    logic [color_width-1:0] r;
    logic [color_width-1:0] g;
    logic [color_width-1:0] b;
  } pix_t;

  typedef enum logic [1:0] {
    PhSync  = 2'd0,
    PhRed   = 2'd1,
    PhGreen = 2'd2,
    PhBlue  = 2'd3
  } phase_e;

  function automatic logic [color_width-1:0] mask_c(input logic [color_width-1:0] c,
                                                     input logic                   full_res);
    return full_res ? c : {c[color_width-1:2], 2'b00};
  endfunction

  // FIFO state
  pix_t            mem_q [FIFO_DEPTH];
  pix_t            mem_d [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Serialiser state
  phase_e                 phase_q, phase_d;
  logic                   nds_q, nds_d;
  logic [color_width-1:0] d_q, d_d;
  logic                   uflow_q, uflow_d;
  logic [UFLOW_CNT_W-1:0] ucnt_q, ucnt_d;
  logic [3:0]             last_sync_q, last_sync_d;
  logic [color_width-1:0] cur_r_q, cur_r_d;
  logic [color_width-1:0] cur_g_q, cur_g_d;
  logic [color_width-1:0] cur_b_q, cur_b_d;

  logic full, empty, push, pop;
  pix_t head, in_pix;

  // Occupancy is registered, so a pixel pushed this cycle is never visible to a pop this cycle.
  assign full  = (count_q == CntW'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  assign in_pix.sync = pix.pix_sync;
  assign in_pix.r    = pix.pix_r;
  assign in_pix.g    = pix.pix_g;
  assign in_pix.b    = pix.pix_b;

  assign push = pix.pix_valid && !full;
  assign pop  = (phase_q == PhSync) && en_i && !empty;

  assign pix.pix_ready = !full;

  // FIFO next state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = in_pix;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Serialiser next state
  always_comb begin
    phase_d     = phase_q;
    nds_d       = nds_q;
    d_d         = d_q;
    uflow_d     = 1'b0;
    ucnt_d      = ucnt_q;
    last_sync_d = last_sync_q;
    cur_r_d     = cur_r_q;
    cur_g_d     = cur_g_q;
    cur_b_d     = cur_b_q;
    unique case (phase_q)
      PhSync: begin
        if (en_i) begin
          phase_d = PhRed;
          nds_d   = 1'b0;
          if (!empty) begin
            d_d         = {{PadW{1'b0}}, head.sync};
            cur_r_d     = head.r;
            cur_g_d     = head.g;
            cur_b_d     = head.b;
            last_sync_d = head.sync;
          end else begin
            // Repeat the previous sync word so the receiver keeps its timing; send black.
            d_d     = {{PadW{1'b0}}, last_sync_q};
            cur_r_d = '0;
            cur_g_d = '0;
            cur_b_d = '0;
            uflow_d = 1'b1;
            if (ucnt_q != '1) begin
              ucnt_d = ucnt_q + UFLOW_CNT_W'(1);
            end
          end
        end else begin
          nds_d = 1'b1;
          d_d   = '0;
        end
      end
      PhRed: begin
        phase_d = PhGreen;
        nds_d   = 1'b1;
        d_d     = mask_c(cur_r_q, n15bit_mode_i);
      end
      PhGreen: begin
        phase_d = PhBlue;
        nds_d   = 1'b1;
        d_d     = mask_c(cur_g_q, n15bit_mode_i);
      end
      PhBlue: begin
        phase_d = PhSync;
        nds_d   = 1'b1;
        d_d     = mask_c(cur_b_q, n15bit_mode_i);
      end
      default: begin
        phase_d = PhSync;
      end
    endcase
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      phase_q     <= PhSync;
      nds_q       <= 1'b1;
      d_q         <= '0;
      uflow_q     <= 1'b0;
      ucnt_q      <= '0;
      last_sync_q <= 4'hF;
      cur_r_q     <= '0;
      cur_g_q     <= '0;
      cur_b_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      phase_q     <= phase_d;
      nds_q       <= nds_d;
      d_q         <= d_d;
      uflow_q     <= uflow_d;
      ucnt_q      <= ucnt_d;
      last_sync_q <= last_sync_d;
      cur_r_q     <= cur_r_d;
      cur_g_q     <= cur_g_d;
      cur_b_q     <= cur_b_d;
    end
  end

  // Storage needs no reset: entries are only read once occupancy says they were written.
  always_ff @(posedge VCLK) begin
    mem_q <= mem_d;
  end

  assign nDSYNC_o    = nds_q;
  assign D_o         = d_q;
  assign phase_o     = phase_q;
  assign uflow_o     = uflow_q;
  assign uflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_n64_vmux.sv
module tb_n64_vmux;
  localparam int unsigned CW = 7;

  typedef struct packed {
    logic [3:0]    sync;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } pix_t;

  logic          VCLK = 1'b0;
  logic          nRST;
  logic          en;
  logic          n15;
  logic          nDSYNC;
  logic [CW-1:0] D;
  logic [1:0]    phase;
  logic          uflow;
  logic [7:0]    ucnt;

  n64_vmux_if #(.color_width(CW)) pix_if ();

  n64_vmux #(
    .color_width(CW),
    .FIFO_DEPTH (2),
    .UFLOW_CNT_W(8)
  ) dut (
    .VCLK         (VCLK),
    .nRST         (nRST),
    .en_i         (en),
    .n15bit_mode_i(n15),
    .pix          (pix_if),
    .nDSYNC_o     (nDSYNC),
    .D_o          (D),
    .phase_o      (phase),
    .uflow_o      (uflow),
    .uflow_cnt_o  (ucnt)
  );

  always #5 VCLK = ~VCLK;

  int         checks = 0;
  int         errors = 0;
  pix_t       exp_q[$];
  int         mon_ph = 0;
  pix_t       mon_pix;
  logic [3:0] last_sync = 4'hF;
  int         uflow_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] mask_m(input logic [CW-1:0] c, input logic full_res);
    logic [CW-1:0] m;
    m = c;
    if (!full_res) m[1:0] = 2'b00;
    return m;
  endfunction

  // Scoreboard: follows the bus one cycle at a time, popping expected pixels at each sync phase.
  task automatic monitor();
    logic [CW-1:0] c;
    logic          have;
    if (mon_ph == 0) begin
      if (nDSYNC === 1'b0) begin
        check("sync_phase_o", 32'(phase), 32'd1);
        if (uflow === 1'b1) begin
          uflow_seen++;
          check("uflow_sync_d", 32'(D), 32'({3'b000, last_sync}));
          check("uflow_cnt", 32'(ucnt), (uflow_seen > 255) ? 32'd255 : 32'(uflow_seen));
          mon_pix = '{sync: last_sync, r: '0, g: '0, b: '0};
        end else begin
          have = (exp_q.size() != 0);
          check("pixel_expected", 32'(have), 32'd1);
          if (have) begin
            mon_pix = exp_q.pop_front();
            last_sync = mon_pix.sync;
            check("sync_d", 32'(D), 32'({3'b000, mon_pix.sync}));
          end else begin
            mon_pix = '{sync: 4'h0, r: '0, g: '0, b: '0};
          end
        end
        mon_ph = 1;
      end else begin
        check("idle_d", 32'(D), 32'd0);
        check("idle_uflow", 32'(uflow), 32'd0);
      end
    end else begin
      c = (mon_ph == 1) ? mon_pix.r : (mon_ph == 2) ? mon_pix.g : mon_pix.b;
      check("data_ndsync", 32'(nDSYNC), 32'd1);
      check("data_uflow", 32'(uflow), 32'd0);
      check("data_d", 32'(D), 32'(mask_m(c, n15)));
      check("data_phase_o", 32'(phase), 32'((mon_ph + 1) % 4));
      mon_ph = (mon_ph == 3) ? 0 : mon_ph + 1;
    end
  endtask

  task automatic step();
    @(posedge VCLK);
    #1;
    monitor();
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    pix_if.pix_valid = 1'b0;
    @(posedge VCLK);
    #1;
    exp_q.delete();
    mon_ph = 0;
    last_sync = 4'hF;
    uflow_seen = 0;
    check("rst_ndsync", 32'(nDSYNC), 32'd1);
    check("rst_d", 32'(D), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_uflow", 32'(uflow), 32'd0);
    check("rst_ucnt", 32'(ucnt), 32'd0);
    check("rst_ready", 32'(pix_if.pix_ready), 32'd1);
    nRST = 1'b1;
  endtask

  task automatic push_pixel(input pix_t p);
    int budget;
    budget = 50;
    pix_if.pix_valid = 1'b1;
    pix_if.pix_sync  = p.sync;
    pix_if.pix_r     = p.r;
    pix_if.pix_g     = p.g;
    pix_if.pix_b     = p.b;
    while (pix_if.pix_ready !== 1'b1 && budget > 0) begin
      step();
      budget--;
    end
    check("push_ready_wait", 32'(budget > 0), 32'd1);
    if (budget > 0) begin
      exp_q.push_back(p);
      step();
    end
    pix_if.pix_valid = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int budget;
    budget = 60;
    while ((exp_q.size() != 0 || mon_ph != 0) && budget > 0) begin
      step();
      budget--;
    end
    check(tag, 32'(budget > 0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix_t p;
    int   saved;
    int   budget;
    nRST = 1'b0;
    en   = 1'b0;
    n15  = 1'b1;
    pix_if.pix_valid = 1'b0;
    pix_if.pix_sync  = 4'h0;
    pix_if.pix_r     = '0;
    pix_if.pix_g     = '0;
    pix_if.pix_b     = '0;

    // Single pixel, full 7-bit colours, then underflow frames repeating sync F.
    do_reset();
    repeat (2) step();
    p = '{sync: 4'hF, r: 7'h55, g: 7'h2A, b: 7'h7F};
    push_pixel(p);
    en = 1'b1;
    repeat (12) step();
    check("pix1_emitted", 32'(exp_q.size()), 32'd0);

    // Same pixel with colour masking, sent while underflow frames are running.
    n15 = 1'b0;
    push_pixel(p);
    wait_drained("pix2_drain");
    repeat (4) step();
    n15 = 1'b1;

    // No pixels at all: underflow every pixel slot, counter saturates.
    do_reset();
    repeat (1210) step();
    check("ucnt_saturated", 32'(ucnt), 32'd255);
    check("uflow_seen_300", 32'(uflow_seen >= 300), 32'd1);

    // Burst of five into a two-entry FIFO while transmit is held off, then released.
    en = 1'b0;
    wait_drained("pre_burst_drain");
    repeat (2) step();
    push_pixel('{sync: 4'h1, r: 7'h01, g: 7'h12, b: 7'h23});
    push_pixel('{sync: 4'h2, r: 7'h34, g: 7'h45, b: 7'h56});
    check("burst_full_ready", 32'(pix_if.pix_ready), 32'd0);
    saved = uflow_seen;
    en = 1'b1;
    push_pixel('{sync: 4'h3, r: 7'h67, g: 7'h78, b: 7'h0F});
    push_pixel('{sync: 4'h4, r: 7'h7E, g: 7'h3C, b: 7'h5A});
    push_pixel('{sync: 4'hA, r: 7'h2D, g: 7'h4B, b: 7'h69});
    wait_drained("burst_drain");
    check("burst_no_uflow", 32'(uflow_seen - saved), 32'd0);

    // Drop enable mid-pixel: the pixel completes, then the bus idles at phase 0.
    push_pixel('{sync: 4'h6, r: 7'h11, g: 7'h22, b: 7'h33});
    budget = 40;
    while (!(exp_q.size() == 0 && mon_ph == 1) && budget > 0) begin
      step();
      budget--;
    end
    check("en_drop_sync_seen", 32'(budget > 0), 32'd1);
    step();
    check("en_drop_at_phase2", 32'(phase), 32'd2);
    en = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      check("en_off_phase", 32'(phase), 32'd0);
      check("en_off_ndsync", 32'(nDSYNC), 32'd1);
    end
    en = 1'b1;
    step();
    check("en_back_uflow", 32'(uflow), 32'd1);
    check("en_back_ndsync", 32'(nDSYNC), 32'd0);
    repeat (3) step();

    // Reset at phase 2 with a second pixel still queued: both are dropped.
    push_pixel('{sync: 4'h5, r: 7'h0A, g: 7'h0B, b: 7'h0C});
    budget = 40;
    while (!(exp_q.size() == 0 && mon_ph == 1) && budget > 0) begin
      step();
      budget--;
    end
    check("rst_mid_sync_seen", 32'(budget > 0), 32'd1);
    push_pixel('{sync: 4'h9, r: 7'h1A, g: 7'h1B, b: 7'h1C});
    budget = 10;
    while (phase != 2'd2 && budget > 0) begin
      step();
      budget--;
    end
    check("rst_mid_phase2", 32'(phase), 32'd2);
    do_reset();
    step();
    check("post_rst_uflow", 32'(uflow), 32'd1);
    check("post_rst_ucnt", 32'(ucnt), 32'd1);
    repeat (7) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
